picmem_arbiter: RTL and testbench

- Arbitrates the single-port 100x100 picture memory between two requesters: the display read path (picture enable / ROM address counter) and a pixel writer (image loader / CPU).
- The display has absolute priority and a fixed 1-cycle read latency.
- Writes are buffered in a small FIFO and drained into free memory cycles.
- In tear-free mode, drains are restricted to vertical blanking.
- Sits between the picture-address logic and the picture memory, in the VGA pixel-clock domain.

---
 rtl/picmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_picmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picmem_arbiter.sv
// picmem_arbiter
//   Shares the single-port picture memory between the display read path and
//   a buffered pixel writer. Display reads always win the port and return
//   data one cycle later. Writes are queued in a small FIFO and drained into
//   cycles the display leaves free, optionally only during vertical blanking.
//
// Ports
//   clk_i, rst_ni          pixel clock, asynchronous active-low reset
//   frame_blank_i          vertical blanking indicator
//   tear_free_i            restrict drains to blanking when set
//   disp_rd_en_i/addr_i    display read request and address
//   disp_valid_o/data_o    display read result (data forced to 0 when invalid)
//   wr_valid_i/addr_i/data_i, wr_ready_o   writer handshake
//   mem_en_o/we_o/addr_o/wdata_o, mem_rdata_i   memory port
//   fifo_level_o           occupied write-buffer entries
//   wr_err_o               sticky: an out-of-range write was dropped
module picmem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 24,
  parameter int PIC_SIZE   = 10000,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_blank_i,
  input  logic              tear_free_i,
  input  logic              disp_rd_en_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_valid_o,
  output logic [DATA_W-1:0] disp_data_o,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [LVL_W-1:0]  fifo_level_o,
  output logic              wr_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DRAIN} state_e;

  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(PIC_SIZE);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_buf_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  data_buf_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ready_q, err_q, disp_valid_q;

  logic rd_req, write_window, grant, accept, in_range, push, pop;

  // The read strobe is gated with reset so the memory port goes quiet the
  // instant reset asserts, even if the display keeps requesting.
  assign rd_req       = disp_rd_en_i & rst_ni;
  assign write_window = ~tear_free_i | frame_blank_i;
  // IDLE is held exactly when the FIFO is empty, so the state alone tells
  // whether there is something to drain.
  assign grant        = (state_q != ST_IDLE) & ~rd_req & write_window;

  assign accept   = wr_valid_i & ready_q;
  assign in_range = {1'b0, wr_addr_i} < ADDR_LIMIT;
  assign push     = accept & in_range;
  assign pop      = grant;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Buffer storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_buf_q[wr_ptr_q] <= wr_addr_i;
      data_buf_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // State register and the rest of the control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q      <= level_d;
      // Registered so a pop out of a full FIFO reopens the writer one cycle
      // later rather than through a combinational path.
      ready_q      <= (level_d != LVL_FULL);
      err_q        <= err_q | (accept & ~in_range);
      disp_valid_q <= disp_rd_en_i;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = push ? ST_PEND : ST_IDLE;
      ST_PEND,
      ST_DRAIN: begin
        if (level_d == '0)  state_d = ST_IDLE;
        else if (grant)     state_d = ST_DRAIN;
        else                state_d = ST_PEND;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: memory port.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rd_req) begin
      mem_en_o   = 1'b1;
      mem_addr_o = disp_addr_i;
    end else if (grant) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = addr_buf_q[rd_ptr_q];
      mem_wdata_o = data_buf_q[rd_ptr_q];
    end
  end

  assign disp_valid_o = disp_valid_q;
  assign disp_data_o  = disp_valid_q ? mem_rdata_i : '0;
  assign wr_ready_o   = ready_q;
  assign fifo_level_o = level_q;
  assign wr_err_o     = err_q;

endmodule

// File: tb/tb_picmem_arbiter.sv
// tb_picmem_arbiter
//   Drives picmem_arbiter with directed scenarios followed by randomized
//   traffic, and checks every cycle against a queue-based reference model
//   holding its own copy of the picture memory.
module tb_picmem_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 24;
  localparam int PIC_SIZE = 10000;
  localparam int DEPTH    = 4;
  localparam int LVL_W    = $clog2(DEPTH) + 1;
  localparam int RAM_N    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_blank = 1'b0, tear_free = 1'b0;
  logic              disp_rd_en = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [LVL_W-1:0]  fifo_level;
  logic              wr_err;

  picmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIC_SIZE(PIC_SIZE),
                   .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_blank_i(frame_blank),
    .tear_free_i(tear_free), .disp_rd_en_i(disp_rd_en),
    .disp_addr_i(disp_addr), .disp_valid_o(disp_valid),
    .disp_data_o(disp_data), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_ready_o(wr_ready), .mem_en_o(mem_en),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .fifo_level_o(fifo_level), .wr_err_o(wr_err));

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory attached to the DUT: synchronous read, write on strobe.
  // Port signals are captured just before the rising edge.
  logic [DATA_W-1:0] ram [RAM_N];
  initial begin
    logic              c_en, c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    for (int i = 0; i < RAM_N; i++) ram[i] = DATA_W'(i * 7919);
    forever begin
      @(negedge clk);
      #4;
      c_en = mem_en; c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
      @(posedge clk);
      if (c_en) begin
        if (c_we) ram[c_addr] = c_wdata;
        else      mem_rdata = ram[c_addr];
      end
    end
  end

  // Reference model: pending writes in a queue, its own picture image.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              q[$];
  logic [DATA_W-1:0] shadow [RAM_N];
  logic              m_valid = 1'b0, m_ready = 1'b0, m_err = 1'b0;
  logic [DATA_W-1:0] m_rd = '0;
  logic              m_grant;

  initial begin
    for (int i = 0; i < RAM_N; i++) shadow[i] = DATA_W'(i * 7919);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_valid = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_rd = '0;
      end else begin
        m_grant = !disp_rd_en && (q.size() > 0) && (!tear_free || frame_blank);
        m_valid = disp_rd_en;
        if (disp_rd_en) m_rd = shadow[disp_addr];
        if (m_grant) begin
          shadow[q[0].a] = q[0].d;
          void'(q.pop_front());
        end
        if (wr_valid && m_ready) begin
          if (int'(wr_addr) < PIC_SIZE) q.push_back('{a: wr_addr, d: wr_data});
          else m_err = 1'b1;
        end
        m_ready = (q.size() != DEPTH);
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    logic              e_grant, e_rd;
    logic [ADDR_W-1:0] e_addr;
    @(negedge clk);
    #2;
    e_rd    = rst_n && disp_rd_en;
    e_grant = rst_n && !disp_rd_en && (q.size() > 0) && (!tear_free || frame_blank);
    e_addr  = e_rd ? disp_addr : (e_grant ? q[0].a : '0);
    chk("mem_en", 32'(mem_en), 32'(e_rd || e_grant));
    chk("mem_we", 32'(mem_we), 32'(e_grant));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (!e_rd) chk("mem_wdata", 32'(mem_wdata), e_grant ? 32'(q[0].d) : 32'd0);
    chk("disp_valid", 32'(disp_valid), 32'(m_valid));
    chk("disp_data", 32'(disp_data), m_valid ? 32'(m_rd) : 32'd0);
    chk("wr_ready", 32'(wr_ready), 32'(m_ready));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("wr_err", 32'(wr_err), 32'(m_err));
  end

  task automatic drive_beat(input logic v, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    wr_valid = v; wr_addr = a; wr_data = d;
  endtask

  initial begin
    int  nacc, nw, rst_cnt;
    bit  got5, acc_prev;

    // Reset held for three cycles, display requesting throughout.
    disp_rd_en = 1'b1; disp_addr = 14'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_disp_valid", 32'(disp_valid), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; disp_rd_en = 1'b0;
    @(negedge clk); #3;
    chk("post_rst_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_mem_en", 32'(mem_en), 32'd0);

    // Display priority: writes queue behind a continuous read.
    @(negedge clk); disp_rd_en = 1'b1; disp_addr = 14'h0005;
    drive_beat(1'b1, 14'h0001, 24'hFFEEDD); #3;
    chk("prio_we0", 32'(mem_we), 32'd0);
    chk("prio_addr0", 32'(mem_addr), 32'h5);
    @(negedge clk); drive_beat(1'b1, 14'h0002, 24'h123456); #3;
    chk("prio_we1", 32'(mem_we), 32'd0);
    @(negedge clk); drive_beat(1'b0, '0, '0); #3;
    chk("prio_level2", 32'(fifo_level), 32'd2);
    chk("prio_we2", 32'(mem_we), 32'd0);
    @(negedge clk); disp_rd_en = 1'b0; #3;
    chk("drain1_we", 32'(mem_we), 32'd1);
    chk("drain1_addr", 32'(mem_addr), 32'h1);
    chk("drain1_data", 32'(mem_wdata), 32'hFFEEDD);
    @(negedge clk); #3;
    chk("drain2_we", 32'(mem_we), 32'd1);
    chk("drain2_addr", 32'(mem_addr), 32'h2);
    chk("drain2_data", 32'(mem_wdata), 32'h123456);
    @(negedge clk); #3;
    chk("drain_done_level", 32'(fifo_level), 32'd0);
    chk("drain_done_en", 32'(mem_en), 32'd0);

    // Read latency at the last legal address.
    @(negedge clk); drive_beat(1'b1, 14'd9999, 24'hABCDEF);
    @(negedge clk); drive_beat(1'b0, '0, '0); #3;
    chk("lat_wr_addr", 32'(mem_addr), 32'd9999);
    @(negedge clk); disp_rd_en = 1'b1; disp_addr = 14'd9999; #3;
    chk("lat_rd_we", 32'(mem_we), 32'd0);
    @(negedge clk); disp_rd_en = 1'b0; #3;
    chk("lat_valid", 32'(disp_valid), 32'd1);
    chk("lat_data", 32'(disp_data), 32'hABCDEF);
    @(negedge clk); #3;
    chk("lat_data_after", 32'(disp_data), 32'd0);

    // Full FIFO in tear-free mode outside blanking.
    tear_free = 1'b1; frame_blank = 1'b0; nacc = 0;
    for (int i = 0; i < 10 && nacc < 4; i++) begin
      @(negedge clk); drive_beat(1'b1, ADDR_W'(100 + nacc), DATA_W'($urandom)); #3;
      if (wr_ready) nacc++;
    end
    chk("full_accepted", 32'(nacc), 32'd4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive_beat(1'b1, 14'd104, 24'h5A5A5A); #3;
      chk("full_ready", 32'(wr_ready), 32'd0);
      chk("full_level", 32'(fifo_level), 32'd4);
      chk("full_no_write", 32'(mem_we), 32'd0);
    end
    @(negedge clk); frame_blank = 1'b1; nw = 0; got5 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #3;
      if (mem_we) nw++;
      if (wr_valid && wr_ready) got5 = 1'b1;
      @(negedge clk);
      if (got5) wr_valid = 1'b0;
      if (got5 && fifo_level == 0) break;
    end
    chk("full_fifth_accepted", 32'(got5), 32'd1);
    chk("full_write_count", 32'(nw), 32'd5);
    tear_free = 1'b0; frame_blank = 1'b0;

    // Out-of-range write.
    @(negedge clk); drive_beat(1'b1, 14'd10000, 24'h000001); #3;
    chk("oor_ready", 32'(wr_ready), 32'd1);
    @(negedge clk); drive_beat(1'b0, '0, '0); #3;
    chk("oor_level", 32'(fifo_level), 32'd0);
    chk("oor_err", 32'(wr_err), 32'd1);
    chk("oor_no_write", 32'(mem_en), 32'd0);
    repeat (3) @(negedge clk);
    #3 chk("oor_err_sticky", 32'(wr_err), 32'd1);

    // Reset in the middle of a drain.
    @(negedge clk); tear_free = 1'b1; frame_blank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      drive_beat(1'b1, ADDR_W'(200 + i), DATA_W'(24'h010101 * (i + 1)));
    end
    @(negedge clk); drive_beat(1'b0, '0, '0); #3;
    chk("mid_level3", 32'(fifo_level), 32'd3);
    @(negedge clk); frame_blank = 1'b1; #3;
    chk("mid_first_we", 32'(mem_we), 32'd1);
    chk("mid_first_addr", 32'(mem_addr), 32'd200);
    @(negedge clk); rst_n = 1'b0; #3;
    chk("mid_rst_en", 32'(mem_en), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    @(negedge clk); #3;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    @(negedge clk); rst_n = 1'b1; tear_free = 1'b0; frame_blank = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #3;
      chk("mid_post_level", 32'(fifo_level), 32'd0);
      chk("mid_post_err", 32'(wr_err), 32'd0);
      chk("mid_post_we", 32'(mem_we), 32'd0);
    end

    // Randomized traffic; the writer holds a beat until it is accepted.
    acc_prev = 1'b0; rst_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; rst_cnt = 2;
      end
      if (!wr_valid || acc_prev) begin
        wr_valid = ($urandom_range(0, 99) < 60);
        if ($urandom_range(0, 49) == 0)
          wr_addr = ADDR_W'($urandom_range(PIC_SIZE, RAM_N - 1));
        else
          wr_addr = ADDR_W'($urandom_range(0, PIC_SIZE - 1));
        wr_data = DATA_W'($urandom);
      end
      disp_rd_en = ($urandom_range(0, 99) < 50);
      disp_addr  = ADDR_W'($urandom_range(0, PIC_SIZE - 1));
      if ($urandom_range(0, 199) == 0) tear_free = ~tear_free;
      if ($urandom_range(0, 15) == 0)  frame_blank = ~frame_blank;
      #3;
      acc_prev = wr_valid && wr_ready && rst_n;
    end

    @(negedge clk); #3;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
